// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;

    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR_ADDR = 16'hFFFC;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VEC_LO = 3'd2,
        ST_VEC_HI = 3'd3,
        ST_HOLD   = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    // Running image checksum: plain mod-256 byte sum.
    function automatic logic [REG_WIDTH-1:0] csum_add(input logic [REG_WIDTH-1:0] acc,
                                                      input logic [REG_WIDTH-1:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream, memory-write and CPU-control signals of the program loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic                  start;
    logic                  s_valid;
    logic [REG_WIDTH-1:0]  s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_din;
    logic                  cpu_reset_n;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH-1:0] byte_count;

    modport master (
        output start, s_valid, s_data, s_last,
        input  s_ready, mem_we, mem_addr, mem_din, cpu_reset_n, busy, done, error, byte_count
    );

    modport slave (
        input  start, s_valid, s_data, s_last,
        output s_ready, mem_we, mem_addr, mem_din, cpu_reset_n, busy, done, error, byte_count
    );

endinterface

// File: rtl/prog_loader.sv
// Boot loader: streams an image into memory, writes the 6502 reset vector, then releases the CPU.
// Build macro LOADER_CHECKSUM_EN makes the s_last byte a mod-256 checksum of the data bytes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h0200,
    parameter logic [ADDR_WIDTH-1:0] VEC_ADDR    = RESET_VECTOR_ADDR,
    parameter int unsigned           HOLD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    prog_loader_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = VEC_ADDR + 16'd1;
    localparam logic [7:0]            HOLD_LAST   = 8'(HOLD_CYCLES);

    loader_state_t         r_state;
    loader_state_t         w_state_nx;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nx;
    logic [7:0]            r_hold_cnt;
    logic [7:0]            w_hold_nx;
    logic                  r_s_ready;
    logic                  w_s_ready_nx;
    logic                  r_mem_we;
    logic                  w_mem_we_nx;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nx;
    logic [REG_WIDTH-1:0]  r_mem_din;
    logic [REG_WIDTH-1:0]  w_mem_din_nx;
    logic                  r_cpu_reset_n;
    logic                  w_cpu_reset_n_nx;
    logic                  r_busy;
    logic                  w_busy_nx;
    logic                  r_done;
    logic                  w_done_nx;
    logic                  r_error;
    logic                  w_error_nx;
    logic [ADDR_WIDTH-1:0] r_byte_count;
    logic [ADDR_WIDTH-1:0] w_byte_count_nx;
    logic                  w_accept;
`ifdef LOADER_CHECKSUM_EN
    logic [REG_WIDTH-1:0]  r_sum;
    logic [REG_WIDTH-1:0]  w_sum_nx;
`endif

    assign w_accept = bus.s_valid && r_s_ready;

    // Next state and next registered outputs; every output is a flop, so writes trail acceptance by one cycle.
    always_comb begin
        w_state_nx       = r_state;
        w_ptr_nx         = r_ptr;
        w_hold_nx        = r_hold_cnt;
        w_s_ready_nx     = 1'b0;
        w_mem_we_nx      = 1'b0;
        w_mem_addr_nx    = r_mem_addr;
        w_mem_din_nx     = r_mem_din;
        w_cpu_reset_n_nx = r_cpu_reset_n;
        w_busy_nx        = r_busy;
        w_done_nx        = r_done;
        w_error_nx       = r_error;
        w_byte_count_nx  = r_byte_count;
`ifdef LOADER_CHECKSUM_EN
        w_sum_nx         = r_sum;
`endif
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (bus.start) begin
                    w_state_nx       = ST_LOAD;
                    w_ptr_nx         = BASE_ADDR;
                    w_byte_count_nx  = 16'd0;
                    w_s_ready_nx     = 1'b1;
                    w_busy_nx        = 1'b1;
                    w_done_nx        = 1'b0;
                    w_error_nx       = 1'b0;
                    w_cpu_reset_n_nx = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nx         = 8'd0;
`endif
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_LOAD: begin
                w_s_ready_nx = 1'b1;
                if (!w_accept) begin
                    w_state_nx = ST_LOAD;
`ifdef LOADER_CHECKSUM_EN
                end else if (bus.s_last) begin
                    w_s_ready_nx = 1'b0;
                    if (bus.s_data == r_sum) begin
                        w_state_nx = ST_VEC_LO;
                    end else begin
                        w_state_nx = ST_ERR;
                        w_busy_nx  = 1'b0;
                        w_error_nx = 1'b1;
                    end
`endif
                end else if (r_ptr == VEC_ADDR) begin
                    // The image would clobber the reset vector: drop the byte and abort.
                    w_state_nx   = ST_ERR;
                    w_s_ready_nx = 1'b0;
                    w_busy_nx    = 1'b0;
                    w_error_nx   = 1'b1;
                end else begin
                    w_mem_we_nx     = 1'b1;
                    w_mem_addr_nx   = r_ptr;
                    w_mem_din_nx    = bus.s_data;
                    w_ptr_nx        = r_ptr + 16'd1;
                    w_byte_count_nx = r_byte_count + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nx        = csum_add(r_sum, bus.s_data);
`else
                    if (bus.s_last) begin
                        w_state_nx   = ST_VEC_LO;
                        w_s_ready_nx = 1'b0;
                    end else begin
                        w_state_nx = ST_LOAD;
                    end
`endif
                end
            end
            ST_VEC_LO: begin
                w_mem_we_nx   = 1'b1;
                w_mem_addr_nx = VEC_ADDR;
                w_mem_din_nx  = BASE_ADDR[7:0];
                w_state_nx    = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                w_mem_we_nx   = 1'b1;
                w_mem_addr_nx = VEC_HI_ADDR;
                w_mem_din_nx  = BASE_ADDR[15:8];
                w_hold_nx     = 8'd0;
                w_state_nx    = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nx       = ST_RUN;
                    w_cpu_reset_n_nx = 1'b1;
                    w_done_nx        = 1'b1;
                    w_busy_nx        = 1'b0;
                end else begin
                    w_hold_nx = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx       = ST_IDLE;
                w_busy_nx        = 1'b0;
                w_cpu_reset_n_nx = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr         <= 16'd0;
            r_hold_cnt    <= 8'd0;
            r_s_ready     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 16'd0;
            r_mem_din     <= 8'd0;
            r_cpu_reset_n <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_byte_count  <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            r_sum         <= 8'd0;
`endif
        end else begin
            r_ptr         <= w_ptr_nx;
            r_hold_cnt    <= w_hold_nx;
            r_s_ready     <= w_s_ready_nx;
            r_mem_we      <= w_mem_we_nx;
            r_mem_addr    <= w_mem_addr_nx;
            r_mem_din     <= w_mem_din_nx;
            r_cpu_reset_n <= w_cpu_reset_n_nx;
            r_busy        <= w_busy_nx;
            r_done        <= w_done_nx;
            r_error       <= w_error_nx;
            r_byte_count  <= w_byte_count_nx;
`ifdef LOADER_CHECKSUM_EN
            r_sum         <= w_sum_nx;
`endif
        end
    end

    assign bus.s_ready     = r_s_ready;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_din     = r_mem_din;
    assign bus.cpu_reset_n = r_cpu_reset_n;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.byte_count  = r_byte_count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a reference model queues expected writes/outcomes, a monitor checks them.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int          HOLD   = 4;
    localparam logic [15:0] BASE_A = 16'h0200;
    localparam logic [15:0] BASE_B = 16'hFFFA;
    localparam logic [15:0] VEC    = 16'hFFFC;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef struct packed { logic dut; logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic dut; logic is_err; logic [15:0] cnt; } res_t;
    typedef struct packed {
        logic s_ready; logic mem_we; logic [15:0] addr; logic [7:0] din;
        logic cpu; logic busy; logic done; logic error; logic [15:0] cnt;
        logic start; logic s_valid; logic s_last;
    } snap_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    prog_loader_if ifa();
    prog_loader_if ifb();

    prog_loader #(.BASE_ADDR(BASE_A), .VEC_ADDR(VEC), .HOLD_CYCLES(HOLD)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    prog_loader #(.BASE_ADDR(BASE_B), .VEC_ADDR(VEC), .HOLD_CYCLES(HOLD)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    wr_t        exp_wr[$];
    res_t       exp_res[$];
    logic [7:0] img[$];
    int         n_cmp, n_bad, cyc, timeouts;
    bit         sim_end;
    int         vhi_cyc[2];
    snap_t      prev[2];
    logic       prev_rst;

    function automatic snap_t snap(input bit b);
        snap_t s;
        if (b) s = {ifb.s_ready, ifb.mem_we, ifb.mem_addr, ifb.mem_din, ifb.cpu_reset_n, ifb.busy,
                    ifb.done, ifb.error, ifb.byte_count, ifb.start, ifb.s_valid, ifb.s_last};
        else   s = {ifa.s_ready, ifa.mem_we, ifa.mem_addr, ifa.mem_din, ifa.cpu_reset_n, ifa.busy,
                    ifa.done, ifa.error, ifa.byte_count, ifa.start, ifa.s_valid, ifa.s_last};
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected writes and outcome of loading img at base.
    task automatic model_load(input bit b, input logic [15:0] base, input bit has_last);
        int n_data = img.size();
        logic [7:0] sum = 8'd0;
        logic [15:0] a;
        bit err = 1'b0;
        logic [15:0] cnt = 16'd0;
        if (CS && has_last) n_data--;
        for (int i = 0; i < n_data; i++) begin
            a = base + 16'(i);
            if (a == VEC) begin err = 1'b1; break; end
            exp_wr.push_back('{dut: b, addr: a, data: img[i]});
            sum += img[i];
            cnt++;
        end
        if (CS && has_last && !err && sum != img[n_data]) err = 1'b1;
        if (has_last && !err) begin
            exp_wr.push_back('{dut: b, addr: VEC, data: base[7:0]});
            exp_wr.push_back('{dut: b, addr: VEC + 16'd1, data: base[15:8]});
        end
        if (err || has_last) exp_res.push_back('{dut: b, is_err: err, cnt: cnt});
    endtask

    task automatic add_csum();
        logic [7:0] s = 8'd0;
        foreach (img[i]) s += img[i];
        if (CS) img.push_back(s);
    endtask

    task automatic drive(input bit b, input logic v, input logic [7:0] d, input logic l);
        if (b) begin ifb.s_valid = v; ifb.s_data = d; ifb.s_last = l; end
        else   begin ifa.s_valid = v; ifa.s_data = d; ifa.s_last = l; end
    endtask

    task automatic set_start(input bit b, input logic v);
        if (b) ifb.start = v; else ifa.start = v;
    endtask

    task automatic pulse_start(input bit b);
        @(posedge clk); #1 set_start(b, 1'b1);
        @(posedge clk); #1 set_start(b, 1'b0);
    endtask

    task automatic send_img(input bit b, input bit has_last, input int gap_pct, input bit poke);
        bit acc;
        int t;
        for (int i = 0; i < img.size(); i++) begin
            while (int'($urandom_range(99, 0)) < gap_pct) begin
                drive(b, 1'b0, 8'h00, 1'b0);
                @(posedge clk); #1;
            end
            drive(b, 1'b1, img[i], has_last && (i == img.size() - 1));
            if (poke && i == 1) set_start(b, 1'b1);
            acc = 1'b0;
            t = 0;
            while (!acc && t < 64) begin
                @(negedge clk);
                acc = b ? ifb.s_ready : ifa.s_ready;
                @(posedge clk); #1;
                t++;
            end
            set_start(b, 1'b0);
            if (!acc) begin timeouts++; drive(b, 1'b0, 8'h00, 1'b0); return; end
        end
        drive(b, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_end(input bit b);
        bit ok = 1'b0;
        int t = 0;
        while (!ok && t < 400) begin
            @(negedge clk);
            ok = b ? (!ifb.busy && (ifb.done || ifb.error)) : (!ifa.busy && (ifa.done || ifa.error));
            t++;
        end
        if (!ok) timeouts++;
    endtask

    task automatic run_load(input bit b, input logic [15:0] base, input bit has_last,
                            input int gap_pct, input bit poke);
        model_load(b, base, has_last);
        pulse_start(b);
        send_img(b, has_last, gap_pct, poke);
        wait_end(b);
    endtask

    initial begin : stim
        int len;
        reset_n = 1'b0; sim_end = 1'b0; timeouts = 0;
        drive(1'b0, 1'b0, 8'h00, 1'b0); drive(1'b1, 1'b0, 8'h00, 1'b0);
        set_start(1'b0, 1'b0); set_start(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        img.delete(); img.push_back(8'hA9); img.push_back(8'h05); img.push_back(8'h00);
        add_csum();
        run_load(1'b0, BASE_A, 1'b1, 0, 1'b0);

        // Every following load restarts from RUN or ERR; the first one uses heavy valid gaps.
        for (int n = 0; n < 6; n++) begin
            len = (n == 0) ? 16 : int'($urandom_range(15, CS ? 0 : 1));
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            add_csum();
            run_load(1'b0, BASE_A, 1'b1, (n == 0) ? 50 : 25, n[0]);
        end

`ifdef LOADER_CHECKSUM_EN
        img.delete(); img.push_back(8'h01); img.push_back(8'h02); img.push_back(8'h03);
        run_load(1'b0, BASE_A, 1'b1, 0, 1'b0);
        img.delete(); img.push_back(8'h01); img.push_back(8'h02); img.push_back(8'h04);
        run_load(1'b0, BASE_A, 1'b1, 0, 1'b0);
        img.delete(); add_csum();
        run_load(1'b0, BASE_A, 1'b1, 0, 1'b0);
`endif

        img.delete(); img.push_back(8'h11); img.push_back(8'h22);
        model_load(1'b0, BASE_A, 1'b0);
        pulse_start(1'b0);
        send_img(1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        img.delete();
        img.push_back(8'h11); img.push_back(8'h22); img.push_back(8'h33); img.push_back(8'h44);
        add_csum();
        run_load(1'b0, BASE_A, 1'b1, 0, 1'b0);

        img.delete(); img.push_back(8'h5A); img.push_back(8'h6B); img.push_back(8'h7C);
        run_load(1'b1, BASE_B, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        sim_end = 1'b1;
    end

    initial begin : monitor
        snap_t c;
        snap_t p;
        wr_t   e;
        res_t  r;
        bit    kb;
        n_cmp = 0; n_bad = 0; cyc = 0; prev_rst = 1'b0;
        vhi_cyc[0] = 0; vhi_cyc[1] = 0;
        prev[0] = '0; prev[1] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                kb = (k != 0);
                c  = snap(kb);
                p  = prev[k];
                if (!reset_n) begin
                    chk("reset_state", 64'({c.s_ready, c.mem_we, c.addr, c.din, c.cpu, c.busy,
                                            c.done, c.error, c.cnt}), 64'd0);
                end else begin
                    if (c.mem_we) begin
                        if (exp_wr.size() == 0) begin
                            chk("write_expected", 64'(exp_wr.size()), 64'd1);
                        end else begin
                            e = exp_wr.pop_front();
                            chk("write", 64'({kb, c.addr, c.din}), 64'({e.dut, e.addr, e.data}));
                        end
                        if (c.addr == VEC + 16'd1) vhi_cyc[k] = cyc;
                    end
                    if (prev_rst && p.s_valid && p.s_ready && p.s_last)
                        chk("ready_drop", 64'(c.s_ready), 64'd0);
                    if (prev_rst && p.start && !p.busy)
                        chk("start_flags", 64'({c.cpu, c.done, c.error, c.busy, c.s_ready, c.cnt}),
                            64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0}));
                    chk("cpu_vs_done", 64'(c.cpu), 64'(c.done));
                    if ((c.done && !p.done) || (c.error && !p.error)) begin
                        if (c.done) begin
                            chk("release_latency", 64'(cyc - vhi_cyc[k]), 64'(HOLD + 1));
                            chk("run_flags", 64'({c.cpu, c.busy, c.error}), 64'({1'b1, 1'b0, 1'b0}));
                        end else begin
                            chk("err_flags", 64'({c.cpu, c.busy, c.done}), 64'd0);
                        end
                        if (exp_res.size() == 0) begin
                            chk("outcome_expected", 64'(exp_res.size()), 64'd1);
                        end else begin
                            r = exp_res.pop_front();
                            chk("outcome", 64'({kb, c.error, c.cnt}), 64'({r.dut, r.is_err, r.cnt}));
                        end
                    end
                end
                prev[k] = c;
            end
            prev_rst = reset_n;
            if (sim_end) begin
                chk("writes_drained", 64'(exp_wr.size()), 64'd0);
                chk("outcomes_drained", 64'(exp_res.size()), 64'd0);
                chk("timeouts", 64'(timeouts), 64'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, sim_end=%0d required 1", sim_end);
        $fatal(1);
    end

endmodule
